oqpsk_bit_source: RTL and testbench

Upstream bit feeder for the OQPSK raised-cosine modulator. Buffers bytes written by the host or a test harness in a small FIFO, serialises them MSB-first, and presents one bit at a time on `BIT_OUT` with `EN_OUT` qualifying it, advancing on each `BIT_REQ` strobe from the modulator. A PRBS7 mode supplies continuous test data without host writes.

---
 rtl/oqpsk_pkg.sv | 22 ++
 rtl/oqpsk_byte_fifo.sv | 66 ++++++
 rtl/oqpsk_bit_source.sv | 157 +++++++++++++++
 tb/tb_oqpsk_bit_source.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oqpsk_pkg.sv
// Shared types and constants for the OQPSK bit source.
//   state_e        : bit source FSM states
//   BYTE_W         : width of a host byte / shift register
//   PRBS_*         : PRBS7 (x^7 + x^6 + 1) width, feedback taps, default seed
package oqpsk_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned PRBS_W     = 7;
  localparam int unsigned PRBS_TAP_A = 6;
  localparam int unsigned PRBS_TAP_B = 5;

  localparam logic [PRBS_W-1:0] PRBS_SEED_DEFAULT = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PRBS  = 2'd3
  } state_e;

endpackage

// File: rtl/oqpsk_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and byte (ignored while full)
//   pop        : consume the head byte (ignored while empty)
//   dout       : head byte, valid whenever !empty
//   full/empty : decoded from the registered occupancy
//   level      : occupancy, 0..DEPTH
module oqpsk_byte_fifo
  import oqpsk_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [BYTE_W-1:0]       din,
  output logic [BYTE_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  // Pointer and occupancy update; power-of-2 depth lets pointers wrap naturally.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; contents are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/oqpsk_bit_source.sv
// Bit feeder for the OQPSK modulator: serialises FIFO bytes MSB-first or
// emits PRBS7, one bit per BIT_REQ strobe.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   WR_VALID/WR_DATA    : host byte write; WR_READY = FIFO not full
//   MODE                : 0 = FIFO data, 1 = PRBS7 (sampled in IDLE only)
//   START               : run request level
//   BIT_REQ             : modulator strobe for the next bit
//   BIT_OUT/EN_OUT      : registered bit and its qualifier
//   UNDERFLOW           : sticky, FIFO ran dry while running
//   BUSY                : FSM not in IDLE
//   LEVEL               : FIFO occupancy
module oqpsk_bit_source
  import oqpsk_pkg::*;
#(
  parameter int unsigned        DEPTH     = 8,
  parameter logic [PRBS_W-1:0]  PRBS_SEED = PRBS_SEED_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    WR_VALID,
  input  logic [BYTE_W-1:0]       WR_DATA,
  output logic                    WR_READY,
  input  logic                    MODE,
  input  logic                    START,
  input  logic                    BIT_REQ,
  output logic                    BIT_OUT,
  output logic                    EN_OUT,
  output logic                    UNDERFLOW,
  output logic                    BUSY,
  output logic [$clog2(DEPTH):0]  LEVEL
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PRBS_W-1:0]   lfsr_q, lfsr_d;
  logic                bit_out_q, bit_out_d;
  logic                en_out_q, en_out_d;
  logic                underflow_q, underflow_d;
  logic                busy_q, busy_d;

  logic                pop_c;
  logic                fifo_full, fifo_empty;
  logic [BYTE_W-1:0]   fifo_dout;

  oqpsk_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (WR_VALID & ~fifo_full),
    .pop   (pop_c),
    .din   (WR_DATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    underflow_d = underflow_q;
    pop_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (MODE) begin
            state_d     = ST_PRBS;
            underflow_d = 1'b0;
          end else if (!fifo_empty) begin
            state_d     = ST_LOAD;
            underflow_d = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        pop_c   = 1'b1;
        shreg_d = fifo_dout;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (BIT_REQ) begin
          if (cnt_q != CNT_LAST) begin
            shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (!START) begin
            state_d = ST_IDLE;
          end else if (!fifo_empty) begin
            // Back-to-back byte: reload straight from the FIFO head, no bubble.
            pop_c   = 1'b1;
            shreg_d = fifo_dout;
            cnt_d   = '0;
          end else begin
            underflow_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_PRBS: begin
        if (BIT_REQ) begin
          lfsr_d = {lfsr_q[PRBS_W-2:0], lfsr_q[PRBS_TAP_A] ^ lfsr_q[PRBS_TAP_B]};
        end
        if (!START) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the next state so EN_OUT drops on the edge entering IDLE.
    en_out_d  = (state_d == ST_SHIFT) || (state_d == ST_PRBS);
    busy_d    = (state_d != ST_IDLE);
    bit_out_d = 1'b0;
    if (state_d == ST_SHIFT) begin
      bit_out_d = shreg_d[BYTE_W-1];
    end else if (state_d == ST_PRBS) begin
      bit_out_d = lfsr_d[PRBS_W-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      lfsr_q      <= PRBS_SEED;
      bit_out_q   <= 1'b0;
      en_out_q    <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      bit_out_q   <= bit_out_d;
      en_out_q    <= en_out_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
    end
  end

  assign WR_READY  = ~fifo_full;
  assign BIT_OUT   = bit_out_q;
  assign EN_OUT    = en_out_q;
  assign UNDERFLOW = underflow_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_oqpsk_bit_source.sv
// Self-checking bench for oqpsk_bit_source: table-driven single-byte vectors,
// directed corner sequences, and a randomized FIFO stream against a bit queue.
module tb_oqpsk_bit_source;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [6:0]  SEED  = 7'h7F;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             mode;
  logic             start;
  logic             bit_req;
  logic             bit_out;
  logic             en_out;
  logic             underflow;
  logic             busy;
  logic [LVL_W-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  oqpsk_bit_source #(
    .DEPTH     (DEPTH),
    .PRBS_SEED (SEED)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .WR_VALID  (wr_valid),
    .WR_DATA   (wr_data),
    .WR_READY  (wr_ready),
    .MODE      (mode),
    .START     (start),
    .BIT_REQ   (bit_req),
    .BIT_OUT   (bit_out),
    .EN_OUT    (en_out),
    .UNDERFLOW (underflow),
    .BUSY      (busy),
    .LEVEL     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_bits;  // expected serial order, first bit in [7]
  } vec_t;

  // PRBS7 reference: s[k+7] = s[k] ^ s[k+1], s[0..6] = seed MSB-first.
  logic prbs_ref [0:299];
  logic prbs_seen [0:299];
  int   pidx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  // Check the 8 bits of one byte while strobing BIT_REQ after each.
  task automatic run_bits(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_en%0d", tag, i), en_out, 1'b1);
      check($sformatf("%s_bit%0d", tag, i), bit_out, exp[7-i]);
      bit_req = 1'b1;
      tick();
      bit_req = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs [4];
    logic [7:0] bits_q [$];
    logic       exp_q [$];
    int         cyc;

    vecs[0] = '{din: 8'hA5, exp_bits: 8'b1010_0101};
    vecs[1] = '{din: 8'h3C, exp_bits: 8'b0011_1100};
    vecs[2] = '{din: 8'h81, exp_bits: 8'b1000_0001};
    vecs[3] = '{din: 8'h6E, exp_bits: 8'b0110_1110};

    for (int k = 0; k < 7; k++) prbs_ref[k] = SEED[6-k];
    for (int k = 7; k < 300; k++) prbs_ref[k] = prbs_ref[k-7] ^ prbs_ref[k-6];

    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; mode = 1'b0; start = 1'b0; bit_req = 1'b0;
    #3;
    check("rst_en", en_out, 1'b0);
    check("rst_bit", bit_out, 1'b0);
    check("rst_uf", underflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_level", level, 0);
    check("rst_wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single bytes: start latency, MSB-first order, underflow on running dry.
    foreach (vecs[i]) begin
      write_byte(vecs[i].din);
      check($sformatf("v%0d_level", i), level, 1);
      start = 1'b1;
      tick();
      check($sformatf("v%0d_load_en", i), en_out, 1'b0);
      check($sformatf("v%0d_load_busy", i), busy, 1'b1);
      tick();
      check($sformatf("v%0d_uf_clr", i), underflow, 1'b0);
      run_bits($sformatf("v%0d", i), vecs[i].exp_bits);
      check($sformatf("v%0d_end_en", i), en_out, 1'b0);
      check($sformatf("v%0d_end_busy", i), busy, 1'b0);
      check($sformatf("v%0d_end_uf", i), underflow, 1'b1);
      start = 1'b0;
      tick();
    end

    // START with empty FIFO stays idle.
    start = 1'b1;
    tick();
    check("empty_start_busy", busy, 1'b0);
    check("empty_start_uf", underflow, 1'b1);
    start = 1'b0;

    // Two bytes back-to-back without an EN_OUT gap.
    write_byte(8'h3C);
    write_byte(8'hFF);
    start = 1'b1;
    tick();
    tick();
    run_bits("b2b_a", 8'h3C);
    run_bits("b2b_b", 8'hFF);
    check("b2b_uf", underflow, 1'b1);
    start = 1'b0;
    tick();

    // Overfill: ninth byte is refused.
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) check("full_wr_ready", wr_ready, 1'b0);
      wr_valid = 1'b1;
      wr_data  = 8'(17 * (i + 1));
      tick();
    end
    wr_valid = 1'b0;
    check("full_level", level, DEPTH);
    check("full_wr_ready2", wr_ready, 1'b0);
    start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) run_bits($sformatf("drain%0d", i), 8'(17 * (i + 1)));
    check("drain_uf", underflow, 1'b1);
    check("drain_level", level, 0);
    check("drain_wr_ready", wr_ready, 1'b1);
    start = 1'b0;
    tick();

    // Stop mid-byte: byte is finished, no underflow.
    write_byte(8'hF0);
    start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stop_en%0d", i), en_out, 1'b1);
      check($sformatf("stop_bit%0d", i), bit_out, (i < 4) ? 1'b1 : 1'b0);
      bit_req = 1'b1;
      tick();
      bit_req = 1'b0;
      if (i == 2) start = 1'b0;
    end
    check("stop_en", en_out, 1'b0);
    check("stop_busy", busy, 1'b0);
    check("stop_uf", underflow, 1'b0);

    // PRBS7: first bits, full period repeat, stop, re-entry without reseed.
    mode  = 1'b1;
    start = 1'b1;
    tick();
    check("prbs_en", en_out, 1'b1);
    check("prbs_busy", busy, 1'b1);
    for (int i = 0; i < 135; i++) begin
      logic [7:0] first8;
      first8 = 8'b1111_1110;
      if (i < 8) check($sformatf("prbs_first%0d", i), bit_out, first8[7-i]);
      check($sformatf("prbs_bit%0d", i), bit_out, prbs_ref[pidx]);
      prbs_seen[pidx] = bit_out;
      if (pidx >= 127) check($sformatf("prbs_rep%0d", pidx), bit_out, prbs_seen[pidx-127]);
      bit_req = 1'b1;
      tick();
      bit_req = 1'b0;
      pidx++;
    end
    start = 1'b0;
    tick();
    check("prbs_stop_en", en_out, 1'b0);
    check("prbs_stop_busy", busy, 1'b0);
    check("prbs_stop_bit", bit_out, 1'b0);
    start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("prbs_reenter%0d", i), bit_out, prbs_ref[pidx]);
      bit_req = 1'b1;
      tick();
      bit_req = 1'b0;
      pidx++;
    end
    start = 1'b0;
    tick();
    mode = 1'b0;

    // Asynchronous reset in the middle of a byte.
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    write_byte(8'hD4);
    start = 1'b1;
    tick();
    tick();
    check("arst_pre_level", level, 3);
    bit_req = 1'b1; tick(); bit_req = 1'b0; tick();
    bit_req = 1'b1; tick(); bit_req = 1'b0;
    check("arst_pre_en", en_out, 1'b1);
    check("arst_pre_bit", bit_out, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", en_out, 1'b0);
    check("arst_bit", bit_out, 1'b0);
    check("arst_level", level, 0);
    check("arst_uf", underflow, 1'b0);
    check("arst_wr_ready", wr_ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized stream: every consumed bit must match the written bytes in order.
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      write_byte(b);
      for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
    end
    start = 1'b1;
    cyc   = 0;
    while (cyc < 4000 && !(cyc >= 2000 && exp_q.size() == 0 && !busy)) begin
      bit_req  = ($urandom_range(0, 2) != 0);
      wr_valid = (cyc < 2000) && ($urandom_range(0, 3) == 0);
      wr_data  = 8'($urandom);
      if (bit_req && en_out) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_bit", 1, 0);
        end else begin
          check($sformatf("stream_c%0d", cyc), bit_out, exp_q.pop_front());
        end
      end
      if (wr_valid && wr_ready) begin
        for (int k = 7; k >= 0; k--) exp_q.push_back(wr_data[k]);
      end
      tick();
      cyc++;
    end
    bit_req  = 1'b0;
    wr_valid = 1'b0;
    check("stream_drained", exp_q.size(), 0);
    check("stream_idle", busy, 1'b0);
    check("stream_uf", underflow, 1'b1);
    start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
